fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and flow-control unit that reads the combinational program memory. It drives the 8-bit fetch address and consumes the returned 16-bit word. CALL, RET and STOP are executed locally using an internal return-address stack. All other instructions pass through a one-entry output register to the decode stage under a valid/ready handshake.

## Interface
- `STACK_DEPTH`, default 8: return-address stack entries; a power of two, minimum 2.
- `RESET_PC`, default 8'h00: fetch address after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  out  8  fetch address to program memory; equals the PC register.
- `data`  in  16  instruction word returned combinationally for `addr` in the same cycle.
- `instr`  out  16  registered instruction to decode.
- `instr_valid`  out  1  `instr` holds an instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `redirect_valid`  in  1  execute-stage branch taken.
- `redirect_addr`  in  8  branch target.
- `halted`  out  1  STOP reached.
- `stack_err`  out  1  stack overflow or underflow; sticky.

## Operation
- Word format: opcode = `data[15:11]`; CALL target = `data[7:0]`; bits [10:8] are ignored.
- Opcode values come from the shared opcode constants.
- FSM states:
  - RUN: fetching.
  - HALT: entered on STOP.
  - ERR: entered on a stack error.
  - HALT and ERR are left only by `reset`.
- Behaviour in RUN, evaluated in priority order each cycle:
  1. `redirect_valid`: pc <= `redirect_addr`; `instr_valid` <= 0 (flush); no decode of `data`; no stack change.
  2. CALL:
     - Stack full: go to ERR; `stack_err` <= 1; pc unchanged.
     - Otherwise: push pc+1; pc <= `data[7:0]`.
     - Nothing is emitted to decode. Proceeds even while the output register is stalled.
  3. RET:
     - Stack empty: go to ERR; `stack_err` <= 1.
     - Otherwise: pc <= top of stack; pop.
     - Nothing is emitted; proceeds even while stalled.
  4. STOP: go to HALT; `halted` <= 1; pc holds; STOP is not emitted.
  5. Any other opcode: if the output register is free (`!instr_valid || instr_ready`), then `instr` <= `data`, `instr_valid` <= 1, pc <= pc+1. Otherwise pc holds and the fetch repeats.
- Output register:
  - A held instruction is dropped when `instr_valid && instr_ready` and no new instruction loads.
  - In HALT and ERR the output register still drains; no new loads.
  - `redirect_valid` is ignored in HALT and ERR.
- PC arithmetic is 8-bit modulo 256. pc+1 from 8'hFF is 8'h00, and a CALL at 8'hFF pushes 8'h00.
- Stack: the pointer `sp` is 0..STACK_DEPTH.
  - Full: `sp == STACK_DEPTH`.
  - Empty: `sp == 0`.
  - Stack storage is not cleared on reset; only `sp` resets.

## Timing
- Reset values: pc = `RESET_PC`, sp = 0, state = RUN, `instr` = 16'h0000, `instr_valid` = 0, `halted` = 0, `stack_err` = 0.
- First fetch address is presented in the first cycle after `reset` deasserts.
- Fetch-to-decode latency: an instruction at address A appears on `instr` with `instr_valid` = 1 one cycle after `addr` = A.
- CALL, RET and redirect each cost one cycle with no instruction emitted. The target address appears on `addr` in the next cycle.
- Sustained throughput with `instr_ready` held at 1: one instruction per cycle.
- `halted` and `stack_err` assert one cycle after the STOP or offending CALL/RET is on `data`.
- Reset mid-operation: all registers return to their reset values in the next cycle, regardless of state or pending handshake.

## Structure
- Shared package/include contents:
  - Opcode constants (CALL, RET, STOP, …).
  - Field-position constants: `OPC_MSB` = 15, `OPC_LSB` = 11, `TGT_W` = 8.
  - The FSM state encoding.
- Sub-module `return_stack`:
  - Parameter `DEPTH`, data width 8.
  - Ports: `push`, `pop`, `wdata`, `rdata` (top, combinational), `full`, `empty`.
  - Push and pop in the same cycle is illegal, and the FSM never issues it.
- The top level holds pc, the FSM and the output register.

## Test plan
- CALL/RET round trip:
  - Program: 0: CALL 8'h02; 1: STOP; 2: RET.
  - Required `addr` sequence after reset: 00, 02, 01.
  - `halted` = 1 in the cycle after `addr` = 01.
  - `instr_valid` is never asserted.
- Stream with stall:
  - Words at 0–3 are non-control opcodes; `instr_ready` = 0 for cycles 2–3.
  - `instr` shows word 0, then word 1; word 1 is held stable while stalled; no word is lost or duplicated.
- Overflow:
  - STACK_DEPTH = 2; address N holds CALL N+1 for N = 0, 1, 2.
  - Two pushes (01, 02) succeed; the third CALL sets `stack_err` = 1 and the FSM enters ERR with `addr` frozen at 02.
- Underflow: RET at address 0 after reset → `stack_err` = 1 next cycle.
- Redirect priority: `redirect_valid` = 1, `redirect_addr` = 8'h40 in the same cycle that `data` is CALL 8'h10 → next `addr` = 40, sp unchanged, pending `instr` flushed.
- Wrap and reset:
  - A CALL at 8'hFF pushes 00; the matching RET returns `addr` = 00.
  - Asserting `reset` while in HALT → `addr` = 00 and `halted` = 0 next cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, field positions and FSM encoding shared by the fetch unit.
package fetch_unit_pkg;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int TGT_W = 8;
  localparam logic [4:0] OP_CALL = 5'h1C;
  localparam logic [4:0] OP_RET = 5'h1D;
  localparam logic [4:0] OP_STOP = 5'h1F;
  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_unit_return_stack.sv
// return_stack: LIFO of return addresses; only the pointer resets, storage keeps stale entries.
module return_stack #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_sp;
  logic [AW-1:0] w_top;
  assign w_top = AW'(r_sp - 1'b1);
  assign rdata = r_mem[w_top];
  assign full = r_sp == (AW+1)'(DEPTH);
  assign empty = r_sp == '0;
  always_ff @(posedge clk) begin
    if (reset) r_sp <= '0;
    else if (push) r_sp <= r_sp + 1'b1;
    else if (pop) r_sp <= r_sp - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) r_mem[r_sp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches from program memory, runs CALL/RET/STOP locally, hands the rest to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  addr,
  input  logic [15:0] data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  output logic        halted,
  output logic        stack_err
);
  state_t r_state, w_state;
  logic [7:0] r_pc, w_pc, w_pc_inc, w_rdata;
  logic [15:0] r_instr;
  logic r_instr_valid, r_halted, r_stack_err;
  logic w_push, w_pop, w_full, w_empty, w_load, w_flush, w_free;
  logic [4:0] w_opc;
  assign w_opc = data[OPC_MSB:OPC_LSB];
  assign w_pc_inc = r_pc + 8'd1;
  assign w_free = !r_instr_valid || instr_ready;
  return_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop),
    .wdata(w_pc_inc), .rdata(w_rdata), .full(w_full), .empty(w_empty)
  );
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_push = 1'b0;
    w_pop = 1'b0;
    w_load = 1'b0;
    w_flush = 1'b0;
    if (r_state == ST_RUN) begin
      if (redirect_valid) begin
        w_pc = redirect_addr;
        w_flush = 1'b1;
      end else if (w_opc == OP_CALL) begin
        w_state = w_full ? ST_ERR : ST_RUN;
        w_push = !w_full;
        w_pc = w_full ? r_pc : data[TGT_W-1:0];
      end else if (w_opc == OP_RET) begin
        w_state = w_empty ? ST_ERR : ST_RUN;
        w_pop = !w_empty;
        w_pc = w_empty ? r_pc : w_rdata;
      end else if (w_opc == OP_STOP) begin
        w_state = ST_HALT;
      end else if (w_free) begin
        w_load = 1'b1;
        w_pc = w_pc_inc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc <= RESET_PC;
      r_instr <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_halted <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_halted <= r_halted || w_state == ST_HALT;
      r_stack_err <= r_stack_err || w_state == ST_ERR;
      if (w_load) r_instr <= data;
      r_instr_valid <= w_flush ? 1'b0 : w_load ? 1'b1 : r_instr_valid && !instr_ready;
    end
  end
  assign addr = r_pc;
  assign instr = r_instr;
  assign instr_valid = r_instr_valid;
  assign halted = r_halted;
  assign stack_err = r_stack_err;
endmodule
